// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared state type, wave-select codes and default widths for the DAC sequencer
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  localparam logic [1:0] WAVE_SINE = 2'd0;
  localparam logic [1:0] WAVE_TRI  = 2'd1;
  localparam logic [1:0] WAVE_SQR  = 2'd2;
  localparam logic [1:0] WAVE_SAW  = 2'd3;

  localparam int DEF_PHASE_W = 16;
  localparam int DEF_ADDR_W  = 10;

endpackage

// File: rtl/dac_phase_acc.sv
// rtl/dac_phase_acc.sv - phase accumulator with step load, phase clear and period carry
module dac_phase_acc
  import dac_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic               load,
  input  logic [PHASE_W-1:0] step_in,
  output logic [ADDR_W-1:0]  addr,
  output logic               carry
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] step;
  logic [PHASE_W:0]   sum;

  assign sum   = {1'b0, phase} + {1'b0, step};
  assign carry = en & sum[PHASE_W];
  assign addr  = phase[PHASE_W-1 -: ADDR_W];

  // A loaded step only affects the add after the load edge, so a swap on a
  // wrap still completes that wrap with the old step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      step  <= PHASE_W'(1);
    end else begin
      if (clear) begin
        phase <= '0;
      end else if (en) begin
        phase <= sum[PHASE_W-1:0];
      end
      if (load) begin
        step <= (step_in == '0) ? PHASE_W'(1) : step_in;
      end
    end
  end

endmodule

// File: rtl/dac_wave_sequencer.sv
// rtl/dac_wave_sequencer.sv - command-driven phase sequencer producing ROM address, table select and valid strobe
module dac_wave_sequencer
  import dac_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CNT_W   = 16,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_wave,
  input  logic [PHASE_W-1:0] cmd_step,
  input  logic [CNT_W-1:0]   cmd_cycles,
  input  logic               stop,
  input  logic               abort,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [1:0]         rom_sel,
  output logic               data_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  seq_state_t         state;
  logic               pend_valid;
  logic [1:0]         pend_wave;
  logic [PHASE_W-1:0] pend_step;
  logic [CNT_W-1:0]   pend_cycles;
  logic [CNT_W-1:0]   act_cycles;
  logic [CNT_W-1:0]   period_cnt;
  logic [ROM_LAT-1:0] vld_sr;

  logic               running;
  logic               hs;
  logic               carry;
  logic               cnt_hit;
  logic               finish;
  logic               go_idle;
  logic               swap;
  logic               acc_clear;
  logic               acc_load;
  logic [PHASE_W-1:0] acc_step;

  always_comb begin
    running   = (state != ST_IDLE);
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RUN:  cmd_ready = !pend_valid;
      default: cmd_ready = 1'b0;
    endcase
    hs      = cmd_valid & cmd_ready;
    cnt_hit = (act_cycles != '0) && ((period_cnt + CNT_W'(1)) == act_cycles);
    // A queued command outranks an expiring count: the next command takes over.
    finish  = carry && ((state == ST_DRAIN) ||
                        ((state == ST_RUN) && !pend_valid && cnt_hit));
    go_idle = running && (abort || finish);
    swap    = (state == ST_RUN) && carry && pend_valid && !abort && !stop;
    acc_clear = !running || go_idle;
    acc_load  = ((state == ST_IDLE) && hs) || swap;
    acc_step  = (state == ST_IDLE) ? cmd_step : pend_step;
  end

  dac_phase_acc #(
    .PHASE_W(PHASE_W),
    .ADDR_W (ADDR_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .en     (running),
    .load   (acc_load),
    .step_in(acc_step),
    .addr   (rom_addr),
    .carry  (carry)
  );

  assign busy       = (state != ST_IDLE);
  assign data_valid = vld_sr[ROM_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pend_valid  <= 1'b0;
      pend_wave   <= WAVE_SINE;
      pend_step   <= '0;
      pend_cycles <= '0;
      act_cycles  <= '0;
      period_cnt  <= '0;
      rom_sel     <= WAVE_SINE;
      wrap        <= 1'b0;
      done        <= 1'b0;
      vld_sr      <= '0;
    end else begin
      wrap      <= carry && !abort;
      done      <= go_idle;
      vld_sr[0] <= running;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      case (state)
        ST_IDLE: begin
          if (hs) begin
            state      <= ST_RUN;
            rom_sel    <= cmd_wave;
            act_cycles <= cmd_cycles;
            period_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (go_idle) begin
            state      <= ST_IDLE;
            pend_valid <= 1'b0;
          end else if (stop) begin
            state      <= ST_DRAIN;
            pend_valid <= 1'b0;
          end else begin
            if (swap) begin
              rom_sel    <= pend_wave;
              act_cycles <= pend_cycles;
              period_cnt <= '0;
              pend_valid <= 1'b0;
            end else if (carry && (act_cycles != '0)) begin
              period_cnt <= period_cnt + CNT_W'(1);
            end
            // hs implies no pending entry, so it can never collide with a swap.
            if (hs) begin
              pend_valid  <= 1'b1;
              pend_wave   <= cmd_wave;
              pend_step   <= cmd_step;
              pend_cycles <= cmd_cycles;
            end
          end
        end
        ST_DRAIN: begin
          if (go_idle) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dac_wave_sequencer.md
# dac_wave_sequencer

Phase-accumulator controller that drives the ROM address of the 125 MHz AD9708 DAC path. It accepts waveform commands (table select, frequency tuning word, period count) over a valid/ready port and generates the ROM address and table select. It also produces a data-valid strobe aligned to the ROM output. Tuning changes made while running take effect glitch-free at the next period wrap. It sits between the PLL/control logic and the waveform ROMs, replacing a free-running address counter.

## Interface
Parameters:
- PHASE_W, 16, accumulator width; tuning-word width.
- ADDR_W, 10, ROM address width; rom_addr = phase[PHASE_W-1 -: ADDR_W].
- CNT_W, 16, period-count width.
- ROM_LAT, 1, ROM read latency in clocks, used for data_valid alignment.

Ports:
- clk, in, 1, 125 MHz DAC clock.
- rst_n, in, 1: **reset, asynchronous, active-low.**
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, command accepted when valid & ready.
- cmd_wave, in, 2, table select (0 sine, 1 triangle, 2 square, 3 saw).
- cmd_step, in, PHASE_W, tuning word; 0 is treated as 1.
- cmd_cycles, in, CNT_W, periods to play; 0 means continuous.
- stop, in, 1, graceful stop: finish the current period.
- abort, in, 1, immediate stop.
- rom_addr, out, ADDR_W, registered ROM address.
- rom_sel, out, 2, registered table select.
- data_valid, out, 1, ROM output valid; dac_en delayed by ROM_LAT.
- busy, out, 1, state != IDLE.
- wrap, out, 1, one-cycle pulse on each period completion.
- done, out, 1, one-cycle pulse on return to IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE:**
  - phase = 0, rom_addr = 0, dac_en = 0.
  - cmd_ready = 1.
  - Handshake loads active step, wave and cycles, clears the period counter, and moves to RUN.
- **RUN:** each clock, phase <= phase + step (mod 2^PHASE_W). A carry-out is a wrap.
  - cmd_ready = !pend_valid. A handshake stores the command in the pending register.
  - On a wrap with pend_valid: load pending into active, clear pend_valid, reset the period counter to 0. The new step applies from the next add.
  - On a wrap without pending and cycles != 0: increment the counter. When the counter reaches cycles, go to IDLE and pulse done.
  - Stop → DRAIN; pending is discarded.
- **DRAIN:**
  - cmd_ready = 0.
  - Accumulate as in RUN. The next wrap → IDLE and pulses done.
  - A finite count that expires first also ends DRAIN.
- **abort** in RUN or DRAIN → IDLE next clock. Phase and pending are cleared, done pulses.
- stop and abort in IDLE are ignored. abort has priority over stop; stop has priority over a same-cycle handshake (that command is dropped, although cmd_ready was 1).
- A wrap and a handshake in the same cycle: the wrap uses the old pending state; the new command becomes pending.
- The phase accumulator never saturates; wrap is modular.
- Output frequency = f_clk·step/2^PHASE_W. With step=64 this gives 122.07 kHz (addr +1 per clock).

## Timing
- Reset values:
  - rom_addr = 0, rom_sel = 0.
  - data_valid = 0, busy = 0, wrap = 0, done = 0.
  - cmd_ready = 1.
  - State IDLE, pend_valid = 0.
- Handshake in cycle N:
  - At N+1: busy = 1, rom_addr = 0, rom_sel = cmd_wave.
  - At N+2: rom_addr = step>>(PHASE_W-ADDR_W).
- data_valid rises at N+1+ROM_LAT.
- wrap pulses the clock after the carry, in the same cycle rom_addr shows the wrapped value.
- done coincides with busy falling and rom_addr returning to 0.
- data_valid falls ROM_LAT clocks later.
- The pending command's rom_sel changes in the same cycle as the wrap pulse; no other rom_sel change occurs mid-period.
- All outputs are registered; no combinational input-to-output path except cmd_ready from state/pend_valid.

## Structure
- Shared package dac_pkg holds:
  - State enum.
  - Wave-select constants WAVE_SINE/TRI/SQR/SAW.
  - Default PHASE_W/ADDR_W.
- One sub-module, dac_phase_acc: accumulator with load/clear and a carry (wrap) output.
- The FSM, pending register, period counter and valid delay line live in the top.

## Test plan
- Reset mid-RUN: assert rst_n low asynchronously → all outputs at reset values immediately; after release, cmd_ready = 1.
- Command step=64, cycles=2, wave=1 → rom_addr counts 0..1023 twice, 2 wrap pulses. Then done, busy low, rom_addr = 0; total 2048 busy clocks.
- Continuous step=64, then a new command with step=128 and wave=0 at addr 500 → the step change and rom_sel = 0 occur only at the next wrap. cmd_ready stays low until then; the following period is 512 clocks.
- stop at addr 300 in continuous mode → addresses continue to 1023, wrap, done. A command offered during DRAIN is not accepted.
- abort at addr 300 → the next clock has busy = 0, rom_addr = 0, done = 1. data_valid falls ROM_LAT clocks later.
- Corner cases:
  - cmd_step = 0 → behaves as step 1 (wrap every 65536 clocks).
  - Same-cycle stop plus handshake in RUN → command dropped, DRAIN entered.
